seq_shift_gen: RTL

Parametrised, self-correcting shift-register sequence generator; successor to the team's fixed 3-bit self-correcting counter. One WIDTH-bit register runs as a ring counter, a Johnson (twisted-ring) counter or a maximal-length LFSR, selected at run time. It supports up/down shifting, parallel load, and one-cycle recovery from illegal states. It feeds timing-sequence and pattern-generation logic in the digital-logic lab designs.

---
 rtl/seq_shift_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_shift_gen.sv
// Self-correcting shift-register sequence generator: ring, Johnson or maximal-length
// LFSR selected at run time, with parallel load and one-edge illegal-state recovery.
module seq_shift_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
  output logic             ERR
);

  if (WIDTH < 3 || WIDTH > 8) begin : g_width_check
    $error("seq_shift_gen: WIDTH must be in 3..8");
  end

  typedef enum logic [1:0] {
    M_RING = 2'b00,
    M_JOHN = 2'b01,
    M_LFSR = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1};

  // Feedback taps of a maximal-length polynomial for each supported width
  localparam logic [7:0] TAPS8 =
    (WIDTH == 3) ? 8'h06 :
    (WIDTH == 4) ? 8'h0C :
    (WIDTH == 5) ? 8'h14 :
    (WIDTH == 6) ? 8'h30 :
    (WIDTH == 7) ? 8'h60 : 8'hB8;
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS8[WIDTH-1:0];

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [3:0]       n_ones;
  logic [3:0]       n_edges;
  logic             legal;
  logic             fb;
  logic [WIDTH-1:0] step_q;

  assign mode = mode_e'(MODE);

  always_comb begin
    n_ones  = '0;
    n_edges = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n_ones = n_ones + 4'(q_q[i]);
    end
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      n_edges = n_edges + 4'(q_q[i] ^ q_q[i+1]);
    end
  end

  always_comb begin
    legal = 1'b1;
    case (mode)
      M_RING:  legal = (n_ones == 4'd1);
      M_JOHN:  legal = (n_edges <= 4'd1);
      M_LFSR:  legal = (q_q != '0);
      default: legal = 1'b1;
    endcase
  end

  always_comb begin
    fb = 1'b0;
    case (mode)
      M_RING:  fb = DIR ? q_q[0] : q_q[WIDTH-1];
      M_JOHN:  fb = DIR ? ~q_q[0] : ~q_q[WIDTH-1];
      M_LFSR:  fb = ^(q_q & TAP_MASK);
      default: fb = 1'b0;
    endcase
    if (DIR && mode != M_LFSR) begin
      step_q = {fb, q_q[WIDTH-1:1]};
    end else begin
      step_q = {q_q[WIDTH-2:0], fb};
    end
  end

  // Load beats correction, so an illegal load is visible for one cycle before repair
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (LOAD) begin
      q_d = D;
    end else if (!legal) begin
      q_d   = SEED;
      err_d = 1'b1;
    end else if (EN && mode != M_HOLD) begin
      q_d    = step_q;
      wrap_d = (step_q == SEED);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= SEED;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule
